// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Brief    : Configuration-chain writer. Accepts bitstream words on a
//            valid/ready stream and serialises them MSB-first onto a scan
//            flip-flop configuration chain. It generates the chain shift clock
//            (prog_clk) and the scan enable (se), and flags completion
//            (cfg_done).
// Options  : `define CCFF_READBACK_EN adds ccff_tail / rb_data / rb_valid, which
//            return the previous chain contents while the new bits shift in.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 1024,
    parameter int CLK_DIV   = 2,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              CK,
    input  logic              RSTN,
`ifdef CCFF_READBACK_EN
    input  logic              ccff_tail,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_valid,
`endif
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              prog_clk,
    output logic              se,
    output logic              busy,
    output logic              cfg_done
);

    // Width of the per-phase divider counter; a one-cycle phase still needs a bit.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Width of the "bits left in the current word" counter.
    localparam int WB_W  = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] c_DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_CHAIN_LEN = CNT_W'(CHAIN_LEN);
    localparam logic [WB_W-1:0]  c_WORD_LAST = WB_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DIV_W-1:0]  r_div,     w_div_nxt;
    logic [DATA_W-1:0] r_word,    w_word_nxt;
    logic [WB_W-1:0]   r_wbits,   w_wbits_nxt;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic              r_head,    w_head_nxt;
    logic              r_pclk,    w_pclk_nxt;
    logic              r_se,      w_se_nxt;
    logic              r_busy,    w_busy_nxt;
    logic              r_done,    w_done_nxt;
    logic              r_ready,   w_ready_nxt;

    logic              w_div_end;
    logic              w_load_start;
    logic              w_accept;
    logic              w_last_bit;
    logic [CNT_W-1:0]  w_bit_cnt_inc;

    // in_ready is only ever high in LOAD, so it doubles as the LOAD qualifier.
    assign w_div_end     = (r_div == c_DIV_LAST);
    assign w_load_start  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept      = in_valid && r_ready;
    assign w_bit_cnt_inc = r_bit_cnt + CNT_W'(1);
    assign w_last_bit    = (r_state == ST_SHIFT) && r_pclk && w_div_end
                           && (w_bit_cnt_inc == c_CHAIN_LEN);

    // State register.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div;
        w_word_nxt    = r_word;
        w_wbits_nxt   = r_wbits;
        w_bit_cnt_nxt = r_bit_cnt;
        w_head_nxt    = r_head;
        w_pclk_nxt    = r_pclk;
        w_se_nxt      = r_se;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_ready_nxt   = r_ready;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_load_start) begin
                    w_state_nxt   = ST_LOAD;
                    w_ready_nxt   = 1'b1;
                    w_se_nxt      = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_bit_cnt_nxt = '0;
                    w_pclk_nxt    = 1'b0;
                    w_head_nxt    = 1'b0;
                end
            end

            ST_LOAD: begin
                // Present the word MSB on the head straight away: this edge
                // opens the low phase of the word's first bit.
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_ready_nxt = 1'b0;
                    w_head_nxt  = in_data[DATA_W-1];
                    w_word_nxt  = in_data << 1;
                    w_wbits_nxt = c_WORD_LAST;
                    w_div_nxt   = '0;
                    w_pclk_nxt  = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (!w_div_end) begin
                    w_div_nxt = r_div + DIV_W'(1);
                end else begin
                    w_div_nxt = '0;
                    if (!r_pclk) begin
                        // End of low phase: rising edge, chain captures the head.
                        w_pclk_nxt = 1'b1;
                    end else begin
                        // End of high phase: the bit is committed.
                        w_pclk_nxt    = 1'b0;
                        w_bit_cnt_nxt = w_bit_cnt_inc;
                        if (w_bit_cnt_inc == c_CHAIN_LEN) begin
                            // Chain full; any leftover bits of this word are dropped.
                            w_state_nxt = ST_DONE;
                            w_head_nxt  = 1'b0;
                            w_se_nxt    = 1'b0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else if (r_wbits == '0) begin
                            // Word exhausted; head keeps the last bit while waiting.
                            w_state_nxt = ST_LOAD;
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_head_nxt  = r_word[DATA_W-1];
                            w_word_nxt  = r_word << 1;
                            w_wbits_nxt = r_wbits - WB_W'(1);
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset forces prog_clk low at once.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_div     <= '0;
            r_word    <= '0;
            r_wbits   <= '0;
            r_bit_cnt <= '0;
            r_head    <= 1'b0;
            r_pclk    <= 1'b0;
            r_se      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_div     <= w_div_nxt;
            r_word    <= w_word_nxt;
            r_wbits   <= w_wbits_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_head    <= w_head_nxt;
            r_pclk    <= w_pclk_nxt;
            r_se      <= w_se_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign in_ready  = r_ready;
    assign ccff_head = r_head;
    assign prog_clk  = r_pclk;
    assign se        = r_se;
    assign busy      = r_busy;
    assign cfg_done  = r_done;

`ifdef CCFF_READBACK_EN
    localparam int RB_W = $clog2(DATA_W + 1);
    localparam logic [RB_W-1:0] c_RB_FULL = RB_W'(DATA_W);

    logic [DATA_W-1:0] r_rb_sh;
    logic [DATA_W-1:0] r_rb_data;
    logic [RB_W-1:0]   r_rb_n;
    logic              r_rb_valid;
    logic              w_rb_sample;
    logic [DATA_W-1:0] w_rb_shifted;
    logic [RB_W-1:0]   w_rb_n_inc;

    // Tail is sampled on the last low-phase cycle, i.e. the edge that raises prog_clk.
    assign w_rb_sample  = (r_state == ST_SHIFT) && !r_pclk && w_div_end;
    assign w_rb_shifted = (r_rb_sh << 1) | DATA_W'(ccff_tail);
    assign w_rb_n_inc   = r_rb_n + RB_W'(1);

    // Collect tail bits into words; flush a left-aligned partial word at DONE.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_rb_sh    <= '0;
            r_rb_data  <= '0;
            r_rb_n     <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (w_load_start) begin
                r_rb_sh <= '0;
                r_rb_n  <= '0;
            end else if (w_rb_sample) begin
                if (w_rb_n_inc == c_RB_FULL) begin
                    r_rb_data  <= w_rb_shifted;
                    r_rb_valid <= 1'b1;
                    r_rb_sh    <= '0;
                    r_rb_n     <= '0;
                end else begin
                    r_rb_sh <= w_rb_shifted;
                    r_rb_n  <= w_rb_n_inc;
                end
            end else if (w_last_bit && (r_rb_n != '0)) begin
                r_rb_data  <= r_rb_sh << (c_RB_FULL - r_rb_n);
                r_rb_valid <= 1'b1;
                r_rb_sh    <= '0;
                r_rb_n     <= '0;
            end
        end
    end

    assign rb_data  = r_rb_data;
    assign rb_valid = r_rb_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_chain_loader
// Brief    : Scoreboard bench for ccff_chain_loader. The driver queues the
//            expected head bit for every bit it hands over; a monitor pops one
//            per prog_clk rise and models the chain as a shift register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int DATA_W    = 8;
    localparam int CHAIN_LEN = 12;
    localparam int CLK_DIV   = 2;
    localparam int TIMEOUT   = 2000;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic              RSTN, start, in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, ccff_head, prog_clk, se, busy, cfg_done;

    logic              start2, in_valid2;
    logic [DATA_W-1:0] in_data2;
    logic              in_ready2, head2, pclk2, se2, busy2, done2;

    logic [CHAIN_LEN-1:0] chain_m   = '0;
    logic [CHAIN_LEN-1:0] exp_chain = '0;
    bit                   exp_q[$];
    logic [DATA_W-1:0]    src_q[$];
    int                   pushed   = 0;
    int                   rise_cnt = 0;

    int vectors     = 0;
    int miscompares = 0;

`ifdef CCFF_READBACK_EN
    logic              ccff_tail;
    logic [DATA_W-1:0] rb_data, rb_data2;
    logic              rb_valid, rb_valid2;
    logic [DATA_W-1:0] rb_exp_q[$];
    assign ccff_tail = chain_m[CHAIN_LEN-1];
`endif

    ccff_chain_loader #(.DATA_W(DATA_W), .CHAIN_LEN(CHAIN_LEN), .CLK_DIV(CLK_DIV)) u_dut (
        .CK(CK), .RSTN(RSTN),
`ifdef CCFF_READBACK_EN
        .ccff_tail(ccff_tail), .rb_data(rb_data), .rb_valid(rb_valid),
`endif
        .start(start), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ccff_head(ccff_head), .prog_clk(prog_clk), .se(se), .busy(busy), .cfg_done(cfg_done)
    );

    ccff_chain_loader #(.DATA_W(DATA_W), .CHAIN_LEN(8), .CLK_DIV(1)) u_dut2 (
        .CK(CK), .RSTN(RSTN),
`ifdef CCFF_READBACK_EN
        .ccff_tail(1'b0), .rb_data(rb_data2), .rb_valid(rb_valid2),
`endif
        .start(start2), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .ccff_head(head2), .prog_clk(pclk2), .se(se2), .busy(busy2), .cfg_done(done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic prev_pclk = 1'b0, prev_done = 1'b0, prev_head = 1'b0, head_at_rise = 1'b0;
    int   high_cnt = 0, low_cnt = 0, head_same = 0;

    always @(negedge CK) begin
        if (!RSTN) begin
            prev_pclk = 1'b0; prev_done = 1'b0; prev_head = 1'b0;
            high_cnt  = 0;    low_cnt   = 0;    head_same = 0;
        end else begin
            head_same = (ccff_head == prev_head) ? head_same + 1 : 1;
            if (prog_clk && !prev_pclk) begin
                check("low_phase_len_ok", low_cnt >= CLK_DIV, 1);
                check("head_setup_ok", head_same >= CLK_DIV + 1, 1);
                check("se_at_rise", se, 1);
                check("busy_at_rise", busy, 1);
                if (exp_q.size() == 0)
                    check("unexpected_rise", rise_cnt + 1, CHAIN_LEN);
                else
                    check("head_bit", ccff_head, exp_q.pop_front());
                chain_m      = {chain_m[CHAIN_LEN-2:0], ccff_head};
                rise_cnt     = rise_cnt + 1;
                head_at_rise = ccff_head;
                high_cnt     = 1;
                low_cnt      = 0;
            end else if (prog_clk) begin
                check("head_hold_high", ccff_head, head_at_rise);
                high_cnt = high_cnt + 1;
            end else if (prev_pclk) begin
                check("high_phase_len", high_cnt, CLK_DIV);
                low_cnt = 1;
            end else begin
                low_cnt = low_cnt + 1;
            end
            if (cfg_done && !prev_done) begin
                check("rises_per_load", rise_cnt, CHAIN_LEN);
                check("exp_q_drained", exp_q.size(), 0);
                check("done_outputs", {busy, se, ccff_head, prog_clk, in_ready}, 0);
                check("chain_contents", chain_m, exp_chain);
            end
            prev_pclk = prog_clk;
            prev_done = cfg_done;
            prev_head = ccff_head;
        end
    end

`ifdef CCFF_READBACK_EN
    always @(negedge CK) begin
        if (RSTN && rb_valid) begin
            if (rb_exp_q.size() == 0) check("rb_unexpected", 1, 0);
            else check("rb_data", rb_data, rb_exp_q.pop_front());
        end
    end
`endif

    // Second instance (CLK_DIV=1, CHAIN_LEN=8): rises, high cycles, accepts.
    int   rises2 = 0, highs2 = 0, accepts2 = 0;
    logic prev2 = 1'b0;
    always @(negedge CK) begin
        if (RSTN) begin
            if (pclk2 && !prev2) begin
                rises2 = rises2 + 1;
                check("t5_head", head2, 1);
            end
            if (pclk2) highs2 = highs2 + 1;
            if (in_valid2 && in_ready2) accepts2 = accepts2 + 1;
            prev2 = pclk2;
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic pulse_start();
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
    endtask

    task automatic issue_word(input logic [DATA_W-1:0] w, output bit ok);
        int t = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && t < TIMEOUT) begin
            @(negedge CK);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        // in_ready is high ahead of the coming edge: the word is taken there.
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (pushed < CHAIN_LEN) begin
                exp_q.push_back(w[i]);
                exp_chain = {exp_chain[CHAIN_LEN-2:0], w[i]};
                pushed++;
            end
        end
        @(negedge CK);
        in_valid = 1'b0;
        check("in_ready_drops", in_ready, 0);
        ok = 1'b1;
    endtask

    task automatic run_load(input int starve, input bit poke);
        bit                ok;
        int                t;
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] last_w = '0;
`ifdef CCFF_READBACK_EN
        logic [DATA_W-1:0] g = '0;
        int                n = 0;
        for (int i = CHAIN_LEN - 1; i >= 0; i--) begin
            g = (g << 1) | DATA_W'(chain_m[i]);
            n++;
            if (n == DATA_W) begin
                rb_exp_q.push_back(g);
                g = '0;
                n = 0;
            end
        end
        if (n != 0) rb_exp_q.push_back(g << (DATA_W - n));
`endif
        pushed    = 0;
        exp_chain = '0;
        rise_cnt  = 0;
        pulse_start();
        while (pushed < CHAIN_LEN) begin
            w = (src_q.size() != 0) ? src_q.pop_front() : DATA_W'($urandom);
            if (starve > 0 && pushed > 0) begin
                t = 0;
                while (!in_ready && t < TIMEOUT) begin
                    @(negedge CK);
                    t++;
                end
                for (int k = 0; k < starve; k++) begin
                    check("starve_in_ready", in_ready, 1);
                    check("starve_prog_clk", prog_clk, 0);
                    check("starve_head_held", ccff_head, last_w[0]);
                    @(negedge CK);
                end
            end
            issue_word(w, ok);
            if (!ok) return;
            last_w = w;
            if (poke && pushed == DATA_W) pulse_start();
        end
        t = 0;
        while (!cfg_done && t < TIMEOUT) begin
            @(negedge CK);
            t++;
        end
        check("cfg_done_reached", cfg_done, 1);
        repeat (3) @(negedge CK);
        check("cfg_done_held", cfg_done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int t;
        RSTN = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        start2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
        repeat (3) @(negedge CK);
        check("reset_outputs", {in_ready, ccff_head, prog_clk, se, busy, cfg_done}, 0);
        RSTN = 1'b1;
        repeat (2) @(negedge CK);
        check("idle_outputs", {in_ready, ccff_head, prog_clk, se, busy, cfg_done}, 0);

        // Two words, last four bits of the second one discarded.
        src_q = {8'hA5, 8'h3C};
        run_load(0, 1'b0);
        check("t1_chain", chain_m, 12'hA53);

        // Source starved for 20 cycles between words.
        src_q = {8'hA5, 8'h3C};
        run_load(20, 1'b0);
        check("t2_chain", chain_m, 12'hA53);

        // start pulsed while shifting is ignored.
        src_q = {8'hA5, 8'h3C};
        run_load(0, 1'b1);
        check("t3_chain", chain_m, 12'hA53);

        // Reset in the middle of a load, then a clean random reload.
        pushed = 0; exp_chain = '0; rise_cnt = 0;
        pulse_start();
        issue_word(8'h5A, ok);
        t = 0;
        while (rise_cnt < 5 && t < TIMEOUT) begin
            @(negedge CK);
            t++;
        end
        check("t4_reached_bit5", rise_cnt >= 5, 1);
        #2 RSTN = 1'b0;
        #1 check("t4_async_reset", {in_ready, ccff_head, prog_clk, se, busy, cfg_done}, 0);
        exp_q.delete();
        @(negedge CK);
        RSTN = 1'b1;
        @(negedge CK);
        run_load(0, 1'b0);

        // Randomised loads with random starvation and stray start pulses.
        for (int k = 0; k < 5; k++)
            run_load(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

`ifdef CCFF_READBACK_EN
        src_q = {8'hA5, 8'h3C};
        run_load(0, 1'b0);
        src_q = {8'h00, 8'h00};
        run_load(0, 1'b0);
        check("t6_rb_drained", rb_exp_q.size(), 0);
`endif

        // CLK_DIV=1, CHAIN_LEN=8, one word of all ones.
        in_data2 = 8'hFF; in_valid2 = 1'b1;
        start2 = 1'b1;
        @(negedge CK);
        start2 = 1'b0;
        t = 0;
        while (!in_ready2 && t < 50) begin
            @(negedge CK);
            t++;
        end
        @(negedge CK);
        t = 0;
        while (!done2 && t < 200) begin
            t++;
            @(negedge CK);
        end
        in_valid2 = 1'b0;
        check("t5_cycles_to_done", t, 16);
        check("t5_rises", rises2, 8);
        check("t5_high_cycles", highs2, 8);
        check("t5_accepts", accepts2, 1);
        check("t5_done_outputs", {done2, busy2, se2, head2, pclk2}, 5'b10000);

        check("final_exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
